// File: rtl/posit_shift_arbiter_if.sv
// Handshake bundle between two shift requesters, the shared shifter and its consumer.
// Latency: none (wires only).
// Backpressure: carries per-requester valid/ready and the result valid/ready pair.
interface posit_shift_arbiter_if #(
    parameter int N  = 8,
    parameter int S  = $clog2(N),
    parameter int ES = 4
);
    localparam int SHW = S + ES + 1;

    logic           req0_valid;
    logic           req0_ready;
    logic [N-1:0]   req0_data;
    logic [SHW-1:0] req0_shamt;

    logic           req1_valid;
    logic           req1_ready;
    logic [N-1:0]   req1_data;
    logic [SHW-1:0] req1_shamt;

    logic           res_valid;
    logic           res_ready;
    logic [N-1:0]   res_data;
    logic           res_sticky;
    logic           res_id;

    // Requesters and consumer side (drives operands and the result ready).
    modport master (
        output req0_valid, req0_data, req0_shamt,
        output req1_valid, req1_data, req1_shamt,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_data, res_sticky, res_id
    );

    // Shifter side (drives readies and the registered result).
    modport slave (
        input  req0_valid, req0_data, req0_shamt,
        input  req1_valid, req1_data, req1_shamt,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_data, res_sticky, res_id
    );
endinterface

// File: rtl/posit_shift_arbiter.sv
// Round-robin shared right shifter with sticky bit; macro POSIT_SHIFT_STICKY_EN enables sticky.
// Latency: 1 cycle from accept to res_valid; back-to-back 1 result/cycle.
// Backpressure: readies drop while a result is held and res_ready is low.
module posit_shift_arbiter #(
    parameter int N  = 8,
    parameter int S  = $clog2(N),
    parameter int ES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    posit_shift_arbiter_if.slave   bus
);
    localparam int SHW = S + ES + 1;

    // The result register is either empty or holding an unconsumed result.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           rr_ptr;
    logic [N-1:0]   data_q;
    logic           id_q;

    logic           can_accept;
    logic           grant_vld;
    logic           grant_id;
    logic           accept;
    logic [N-1:0]   sel_data;
    logic [SHW-1:0] sel_shamt;
    logic [N-1:0]   shifted;

    // Pick a winner: a lone requester wins outright, a tie goes to rr_ptr.
    always_comb begin
        grant_vld = bus.req0_valid | bus.req1_valid;
        grant_id  = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = rr_ptr;
        end else if (bus.req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // The slot is free when empty or when the held result leaves this cycle.
    assign can_accept     = (state == EMPTY) || bus.res_ready;
    assign bus.req0_ready = can_accept && grant_vld && !grant_id;
    assign bus.req1_ready = can_accept && grant_vld &&  grant_id;
    // The winner is valid by construction, so a grant on a free slot is an accept.
    assign accept         = can_accept && grant_vld;

    // Steer the winning operand into the single shared shifter.
    always_comb begin
        sel_data  = bus.req0_data;
        sel_shamt = bus.req0_shamt;
        if (grant_id) begin
            sel_data  = bus.req1_data;
            sel_shamt = bus.req1_shamt;
        end
    end

    // Full-width shift amount: anything >= N flushes the operand to zero.
    assign shifted = sel_data >> sel_shamt;

    // Next state: a new accept always fills; otherwise a consumed result empties.
    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = FULL;
        end else if ((state == FULL) && bus.res_ready) begin
            state_nxt = EMPTY;
        end
    end

    // State register; reset discards any held result immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Round-robin pointer hands priority to the other requester after each accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (accept) begin
            rr_ptr <= ~grant_id;
        end
    end

    // Result payload loads only on accept so it stays stable while held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            id_q   <= 1'b0;
        end else if (accept) begin
            data_q <= shifted;
            id_q   <= grant_id;
        end
    end

`ifdef POSIT_SHIFT_STICKY_EN
    logic sticky_nxt;
    logic sticky_q;

    // Sticky is the OR of every operand bit whose position lies below the shift amount.
    always_comb begin
        sticky_nxt = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (SHW'(i) < sel_shamt) begin
                sticky_nxt = sticky_nxt | sel_data[i];
            end
        end
    end

    // Sticky register follows the payload load rule.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if (accept) begin
            sticky_q <= sticky_nxt;
        end
    end

    assign bus.res_sticky = sticky_q;
`else
    assign bus.res_sticky = 1'b0;
`endif

    assign bus.res_valid = (state == FULL);
    assign bus.res_data  = data_q;
    assign bus.res_id    = id_q;

endmodule

// File: doc/posit_shift_arbiter.md
Name: posit_shift_arbiter

Overview:
- Shares one right-shift alignment datapath between two requesters, e.g. operand alignment for two posit adder lanes.
- Uses round-robin arbitration with a valid/ready handshake on each request port.
- Performs the shift in a single cycle and computes the sticky (shifted-out OR) bit.
- Holds the registered result, tagged with the requester id, until the consumer accepts it.

Parameters:
- N, 8, data width in bits.
- S, log2(N) (3 for N=8), width of the in-range shift index.
- ES, 4, exponent-size parameter; shift amounts are S+ES+1 bits wide.

Ports:
- clk  input  1  clock; all state on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operand.
- req0_ready  output  1  requester 0 accepted this cycle.
- req0_data  input  N  requester 0 operand.
- req0_shamt  input  S+ES+1  requester 0 right-shift amount, unsigned.
- req1_valid  input  1  requester 1 has an operand.
- req1_ready  output  1  requester 1 accepted this cycle.
- req1_data  input  N  requester 1 operand.
- req1_shamt  input  S+ES+1  requester 1 right-shift amount, unsigned.
- res_valid  output  1  result register holds an unconsumed result.
- res_ready  input  1  consumer accepts the result.
- res_data  output  N  shifted operand.
- res_sticky  output  1  OR of all bits shifted out.
- res_id  output  1  requester that produced the result.

Behaviour:
- Clocking and reset: single clock domain. Reset is asynchronous and active-low; clk and rst_n are the only clock and reset.
- Reset state: res_valid=0, res_data=0, res_sticky=0, res_id=0, rr_ptr=0 (requester 0 has priority).
- States: EMPTY (res_valid=0) and FULL (res_valid=1). The state is represented by res_valid itself.
- Slot free: can_accept = !res_valid || res_ready.
- Grant (combinational):
  - Only one requester valid: that requester wins.
  - Both valid: the requester equal to rr_ptr wins.
  - Neither valid: no grant.
- Ready: reqX_ready = can_accept && grant==X. Ready never depends on the requester's own valid beyond the grant logic. Both readies are never 1 together.
- Accept (reqX_valid && reqX_ready) at the clock edge:
  - res_data <= data >> shamt.
  - res_sticky <= |(data & ((1<<shamt)-1)).
  - res_id <= X; res_valid <= 1; rr_ptr <= ~X.
- Large shifts: if shamt >= N, res_data=0 and res_sticky=|data. The full S+ES+1-bit amount is honoured; there is no truncation to S bits.
- shamt=0: data passes through and sticky=0.
- FULL with res_ready=1 and no accept: res_valid <= 0 next cycle; data, sticky and id keep their old values.
- FULL with res_ready=1 and an accept in the same cycle: the new result replaces the old one and res_valid stays 1. This gives back-to-back throughput of 1 result per cycle.
- FULL with res_ready=0: no grant; result outputs are stable until accepted.
- Latency: 1 cycle from accept to res_valid.
- rr_ptr changes only on an accept.
- Reset mid-operation: a held result is discarded immediately. Requesters must re-present; no partial transfer is possible.
- Requester inputs are don't-care when the corresponding valid=0.

Optional Feature:
- Macro: POSIT_SHIFT_STICKY_EN.
- Defined: res_sticky is computed as above.
- Undefined: res_sticky is tied to 0 and the sticky logic is removed. Data, handshake and arbitration behaviour are identical.

Test Plan:
- Reset then single request: req0 data=8'b1011_0110, shamt=3, res_ready=1 → req0_ready=1 in the same cycle. Next cycle: res_valid=1, res_data=8'b0001_0110, res_sticky=1, res_id=0.
- Contention: req0 and req1 both valid every cycle, res_ready=1 → grants alternate 0,1,0,1 starting with 0. One result per cycle; res_id toggles accordingly.
- Backpressure: res_ready=0 while FULL with data=8'hF0, shamt=4 → result holds res_data=8'h0F, sticky=0. Both readies stay 0 for 5 cycles. Raising res_ready gives a single handoff.
- Large and zero shift: data=8'h81 with shamt=8 → res_data=0, sticky=1. Then shamt=200 → res_data=0, sticky=1. Then shamt=0 → res_data=8'h81, sticky=0.
- Async reset while FULL: assert rst_n=0 mid-cycle → res_valid falls to 0 without a clock edge. rr_ptr=0 after release.
- Sticky macro off: rerun scenario 1 → res_sticky=0 and res_data unchanged.
